fetch_response_buffer: RTL and testbench

- In-order instruction fetch responder sitting between the PC register (fetch stage) and instruction memory, feeding decode.
- Accepts one PC per cycle, issues a memory read, and tracks up to DEPTH outstanding fetches.
- Pairs each returned instruction with its PC and delivers the pairs to decode via valid/ready.
- On a redirect flush, drops all queued work and silently discards responses still in flight from the old path.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_response_buffer.sv | 105 ++++++++++
 tb/tb_fetch_response_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the in-order fetch response buffer.
// Entry layout is fixed here; the top-level width parameters default to these values.
package fetch_pkg;

  localparam int FETCH_DEPTH  = 4;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int FETCH_PTR_W  = $clog2(FETCH_DEPTH);

  // addi x0, x0, 0
  localparam logic [31:0] FETCH_NOP = 32'h00000013;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
    logic                    filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_response_buffer.sv
// Pairs in-order instruction memory responses with their PCs and hands them to decode.
// Latency: response in cycle N is visible to decode in cycle N+1; 1 instr/cycle sustained.
// Backpressure: PCs stall when allocated + flushed-in-flight entries fill DEPTH; decode stalls via iDecodeReady.
module fetch_response_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH  = FETCH_DEPTH,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPCValid,
  input  logic [ADDR_W-1:0]        iPC,
  output logic                     oPCReady,
  output logic                     oMemReqValid,
  output logic [ADDR_W-1:0]        oMemReqAddr,
  input  logic                     iMemReqReady,
  input  logic                     iMemRspValid,
  input  logic [DATA_W-1:0]        iMemRspData,
  input  logic                     iFlush,
  output logic                     oInstrValid,
  output logic [DATA_W-1:0]        oInstr,
  output logic [ADDR_W-1:0]        oInstrPC,
  input  logic                     iDecodeReady,
  output logic [$clog2(DEPTH):0]   oDropCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] head_ptr, fill_ptr, tail_ptr;
  // alloc: entries owned by the current path; pend: allocated but not yet filled;
  // drop: old-path responses still expected from memory.
  logic [CNT_W-1:0] alloc_cnt, pend_cnt, drop_cnt;
  logic [CNT_W:0]   occupancy;
  logic             slot_free;
  logic             rsp_keep;
  logic             deliver;

  always_comb begin
    occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    slot_free = occupancy < (CNT_W+1)'(DEPTH);
  end

  assign oMemReqValid = iPCValid & slot_free & ~iFlush & ~iRst;
  assign oMemReqAddr  = iPC;
  assign oPCReady     = oMemReqValid & iMemReqReady;

  assign rsp_keep     = iMemRspValid & (drop_cnt == '0);

  assign oInstrValid  = entries[head_ptr].filled & (alloc_cnt != '0) & ~iFlush;
  assign oInstr       = entries[head_ptr].instr;
  assign oInstrPC     = entries[head_ptr].pc;
  assign deliver      = oInstrValid & iDecodeReady;

  assign oDropCount   = drop_cnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      head_ptr  <= '0;
      fill_ptr  <= '0;
      tail_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (iFlush) begin
      // Unfilled requests become drops; a response this cycle belongs to the old path.
      head_ptr  <= '0;
      fill_ptr  <= '0;
      tail_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_cnt + pend_cnt - CNT_W'(iMemRspValid);
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
    end else begin
      if (oPCReady) begin
        entries[tail_ptr].pc     <= iPC;
        entries[tail_ptr].filled <= 1'b0;
        tail_ptr                 <= tail_ptr + 1'b1;
      end
      if (iMemRspValid) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - 1'b1;
        end else begin
          entries[fill_ptr].instr  <= iMemRspData;
          entries[fill_ptr].filled <= 1'b1;
          fill_ptr                 <= fill_ptr + 1'b1;
        end
      end
      if (deliver) begin
        entries[head_ptr] <= '0;
        head_ptr          <= head_ptr + 1'b1;
      end
      alloc_cnt <= alloc_cnt + CNT_W'(oPCReady) - CNT_W'(deliver);
      pend_cnt  <= pend_cnt + CNT_W'(oPCReady) - CNT_W'(rsp_keep);
    end
  end

  rsp_has_owner: assert property (@(posedge iClk) disable iff (iRst)
    iMemRspValid |-> (drop_cnt != '0 || pend_cnt != '0));

endmodule

// File: tb/tb_fetch_response_buffer.sv
// Randomized scoreboard bench for fetch_response_buffer against a queue-based model.
module tb_fetch_response_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iPCValid;
  logic [31:0] iPC;
  logic        oPCReady;
  logic        oMemReqValid;
  logic [31:0] oMemReqAddr;
  logic        iMemReqReady;
  logic        iMemRspValid;
  logic [31:0] iMemRspData;
  logic        iFlush;
  logic        oInstrValid;
  logic [31:0] oInstr;
  logic [31:0] oInstrPC;
  logic        iDecodeReady;
  logic [2:0]  oDropCount;

  always #5 iClk = ~iClk;

  fetch_response_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .iClk(iClk), .iRst(iRst),
    .iPCValid(iPCValid), .iPC(iPC), .oPCReady(oPCReady),
    .oMemReqValid(oMemReqValid), .oMemReqAddr(oMemReqAddr), .iMemReqReady(iMemReqReady),
    .iMemRspValid(iMemRspValid), .iMemRspData(iMemRspData),
    .iFlush(iFlush),
    .oInstrValid(oInstrValid), .oInstr(oInstr), .oInstrPC(oInstrPC),
    .iDecodeReady(iDecodeReady), .oDropCount(oDropCount)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } pair_t;
  typedef struct { logic [31:0] addr; int cyc; } req_t;

  pair_t       sb[$];       // filled, undelivered instructions in order
  logic [31:0] pend_q[$];   // accepted PCs awaiting their response
  req_t        mq[$];       // memory-side request queue
  int          m_drop  = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          n_deliv = 0;
  bit          in_rst  = 1'b1;
  bit          exp_acc = 1'b0;
  bit          acc_seen = 1'b0;
  bit          redirect = 1'b0;
  logic [31:0] pc_cur  = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00500093 ^ (a << 7);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs to the model state at the start of this cycle.
  always @(negedge iClk) begin
    bit ev;
    if (!in_rst) begin
      ev      = (sb.size() > 0) && !iFlush;
      exp_acc = iPCValid && (pend_q.size() + sb.size() + m_drop < DEPTH) && !iFlush && iMemReqReady;
      check("pc_ready", oPCReady, exp_acc);
      check("drop_count", oDropCount, m_drop);
      check("instr_valid", oInstrValid, ev);
      if (ev && oInstrValid) begin
        check("instr_pc", oInstrPC, sb[0].pc);
        check("instr_data", oInstr, sb[0].instr);
      end
      if (ev && iDecodeReady) begin
        void'(sb.pop_front());
        n_deliv++;
      end
    end else begin
      exp_acc = 1'b0;
    end
  end

  // Memory: records each handshaken request for an in-order reply later.
  always @(negedge iClk) begin
    acc_seen = !in_rst && oMemReqValid && iMemReqReady;
    if (acc_seen) mq.push_back('{addr: oMemReqAddr, cyc: cyc});
  end

  // Reference model: advances at the clock edge from the inputs of the ending cycle.
  always @(posedge iClk) begin
    pair_t p;
    cyc++;
    if (!in_rst && !iRst) begin
      if (iFlush) begin
        m_drop += pend_q.size() - (iMemRspValid ? 1 : 0);
        pend_q.delete();
        sb.delete();
      end else begin
        if (iMemRspValid) begin
          if (m_drop > 0) m_drop--;
          else if (pend_q.size() > 0) begin
            p.pc    = pend_q.pop_front();
            p.instr = mem_word(p.pc);
            sb.push_back(p);
          end
        end
        if (exp_acc) pend_q.push_back(iPC);
      end
    end
  end

  task automatic drv(input bit pcv, input bit mrdy, input bit rsp, input bit dec, input bit fl);
    req_t r;
    @(posedge iClk);
    #1;
    if (redirect) begin
      pc_cur   = (32'h100 + 32'($urandom_range(0, 255)) * 4);
      redirect = 1'b0;
    end else if (acc_seen) begin
      pc_cur += 4;
    end
    iPCValid     = pcv;
    iPC          = pc_cur;
    iMemReqReady = mrdy;
    iDecodeReady = dec;
    iFlush       = fl;
    if (fl) redirect = 1'b1;
    if (rsp && mq.size() > 0 && mq[0].cyc < cyc) begin
      r            = mq.pop_front();
      iMemRspValid = 1'b1;
      iMemRspData  = mem_word(r.addr);
    end else begin
      iMemRspValid = 1'b0;
      iMemRspData  = FETCH_NOP;
    end
  endtask

  task automatic rand_phase(input int n, input int p_pc, input int p_mr, input int p_rsp,
                            input int p_dec, input int p_fl);
    for (int i = 0; i < n; i++)
      drv($urandom_range(0, 99) < p_pc, $urandom_range(0, 99) < p_mr,
          $urandom_range(0, 99) < p_rsp, $urandom_range(0, 99) < p_dec,
          $urandom_range(0, 99) < p_fl);
  endtask

  initial begin
    iRst = 1'b1; iPCValid = 1'b1; iPC = 32'h0; iMemReqReady = 1'b1;
    iMemRspValid = 1'b0; iMemRspData = FETCH_NOP; iFlush = 1'b0; iDecodeReady = 1'b1;
    #3;
    check("rst_instr_valid", oInstrValid, 0);
    check("rst_pc_ready", oPCReady, 0);
    check("rst_mem_req", oMemReqValid, 0);
    check("rst_drop", oDropCount, 0);
    check("rst_instr", oInstr, 0);
    check("rst_instr_pc", oInstrPC, 0);
    @(posedge iClk); #1;
    iRst = 1'b0; iPCValid = 1'b0; in_rst = 1'b0;

    // single fetch with 2-cycle memory latency
    drv(1, 1, 0, 1, 0);
    drv(0, 1, 0, 1, 0);
    drv(0, 1, 1, 1, 0);
    repeat (3) drv(0, 1, 0, 1, 0);
    // streaming with 1-cycle latency
    repeat (12) drv(1, 1, 1, 1, 0);
    repeat (4) drv(0, 1, 1, 1, 0);
    // full under decode backpressure, then release
    repeat (10) drv(1, 1, 1, 0, 0);
    repeat (8) drv(1, 1, 1, 1, 0);
    repeat (4) drv(0, 1, 1, 1, 0);
    // flush with three requests in flight
    repeat (3) drv(1, 1, 0, 1, 0);
    drv(0, 1, 0, 1, 1);
    repeat (4) drv(0, 1, 1, 1, 0);
    repeat (2) drv(1, 1, 1, 1, 0);
    repeat (4) drv(0, 1, 1, 1, 0);
    // flush coincident with a response
    repeat (2) drv(1, 1, 0, 0, 0);
    drv(0, 1, 1, 0, 1);
    repeat (6) drv(0, 1, 1, 1, 0);

    rand_phase(3000, 80, 85, 70, 60, 3);

    // async reset between edges with entries buffered
    repeat (6) drv(1, 1, 1, 0, 0);
    #2;
    iRst = 1'b1; in_rst = 1'b1;
    #1;
    check("arst_instr_valid", oInstrValid, 0);
    check("arst_pc_ready", oPCReady, 0);
    check("arst_drop", oDropCount, 0);
    sb.delete(); pend_q.delete(); mq.delete(); m_drop = 0; redirect = 1'b0;
    iMemRspValid = 1'b0; iFlush = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    pc_cur = 32'h0; iPC = pc_cur; iRst = 1'b0; in_rst = 1'b0;

    rand_phase(1000, 90, 90, 80, 80, 2);
    repeat (40) drv(0, 1, 1, 1, 0);
    #1;
    check("drain_drop", oDropCount, 0);
    check("drain_valid", oInstrValid, 0);
    check("delivered_enough", n_deliv > 500, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
